// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle integer multiply/divide unit for the EXECUTE stage.
// Implements MULT, MULTU, DIV and DIVU into the HI/LO registers, plus MTHI and
// MTLO writes. A start/busy/done handshake lets hazard logic stall on MFHI/MFLO.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous, active-high reset
//   start  - request a new operation (sampled only while idle)
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   - operands (multiplicand/dividend, multiplier/divisor)
//   hi_we  - MTHI: write wdata into HI
//   lo_we  - MTLO: write wdata into LO
//   wdata  - data for MTHI/MTLO
//   busy   - operation in progress
//   done   - one-cycle pulse, HI/LO hold the new result
//   hi, lo - architectural HI/LO registers
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt;
   logic                 is_div, neg_a, neg_b, b_zero;
   logic [2*WIDTH-1:0]   acc;      // mult: product accumulator; div: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0]   mcand;    // shifted multiplicand
   logic [WIDTH-1:0]     mb_q;     // mult: shifting multiplier; div: divisor

   logic                 sa, sb;
   logic [WIDTH-1:0]     ma, mb;
   logic [WIDTH:0]       trial;
   logic [2*WIDTH-1:0]   acc_step;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo, rem, res_hi, res_lo;

   // operand magnitudes; unsigned ops never set the sign flags
   always_comb begin
      sa = ~op[0] & a[WIDTH-1];
      sb = ~op[0] & b[WIDTH-1];
      ma = sa ? -a : a;
      mb = sb ? -b : b;
   end

   // one iteration of shift-add or restoring division
   always_comb begin
      trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mb_q};
      acc_step = acc;
      if (is_div) begin
         // no borrow means the shifted remainder covered the divisor
         if (!trial[WIDTH])
            acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
      end else if (mb_q[0]) begin
         acc_step = acc + mcand;
      end
   end

   // sign correction; a zero divisor yields all-ones quotient and hi = a
   always_comb begin
      prod = (neg_a ^ neg_b) ? -acc : acc;
      quo  = acc[WIDTH-1:0];
      rem  = acc[2*WIDTH-1:WIDTH];
      if (is_div) begin
         res_lo = b_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
         res_hi = neg_a ? -rem : rem;
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = (state_q != IDLE);
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt == CW'(WIDTH-1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         b_zero  <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         mb_q    <= '0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == FIX);
         case (state_q)
            IDLE: begin
               if (start) begin
                  is_div <= op[1];
                  neg_a  <= sa;
                  neg_b  <= sb;
                  b_zero <= (b == '0);
                  mb_q   <= mb;
                  mcand  <= {{WIDTH{1'b0}}, ma};
                  acc    <= op[1] ? {{WIDTH{1'b0}}, ma} : '0;
                  cnt    <= '0;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            RUN: begin
               cnt <= cnt + CW'(1);
               acc <= acc_step;
               if (!is_div) begin
                  mcand <= {mcand[2*WIDTH-2:0], 1'b0};
                  mb_q  <= {1'b0, mb_q[WIDTH-1:1]};
               end
            end
            FIX: begin
               hi <= res_hi;
               lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
